// File: rtl/apb_timer_if.sv
// APB slave-side bus bundle for apb_timer.
// The master modport drives the request; the slave answers with data/ready.
interface apb_timer_if;
    logic [9:0]  paddr;
    logic        psel;
    logic [1:0]  peripheral_select;
    logic        penable;
    logic        pwrite;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;

    modport master (
        output paddr, psel, peripheral_select, penable, pwrite, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  paddr, psel, peripheral_select, penable, pwrite, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_timer.sv
// 16-bit prescaled down-counting timer with an APB slave port.
// Level irq on expiry; optional auto-reload from LOAD.
module apb_timer #(
    parameter logic [1:0] SLAVE_ID    = 2'd1,
    parameter int         WAIT_STATES = 0
) (
    input  logic        pclk,
    input  logic        presetn,
    apb_timer_if.slave  bus,
    output logic        irq
);
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_LOAD   = 3'd1;
    localparam logic [2:0] A_COUNT  = 3'd2;
    localparam logic [2:0] A_PRESC  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic        sel;
    logic [1:0]  phase;
    logic        pready;
    logic        hit;
    logic [2:0]  off;
    logic        wr_en;
    logic        rd_en;
    logic        tick;
    logic        expire;
    logic [15:0] rdata;

    logic [2:0]  wcnt_q, wcnt_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] load_q, load_d;
    logic [15:0] count_q, count_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        expired_q, expired_d;

    assign sel    = bus.psel && (bus.peripheral_select == SLAVE_ID);
    assign hit    = (bus.paddr[9:3] == 7'd0);
    assign off    = bus.paddr[2:0];
    // Ready is masked by reset so a transfer caught by reset never completes.
    assign pready = (phase == ST_ACCESS) && (wcnt_q == WS) && presetn;
    assign wr_en  = pready && bus.pwrite && hit;
    assign rd_en  = pready && !bus.pwrite && hit;
    assign tick   = ctrl_q[0] && (pcnt_q == presc_q);
    assign expire = tick && (count_q == 16'd0);

    // Decode the bus phase seen this cycle from select/enable.
    always_comb begin
        phase = ST_IDLE;
        if (sel) begin
            phase = bus.penable ? ST_ACCESS : ST_SETUP;
        end
    end

    // Wait-state counter: counts ACCESS cycles, cleared otherwise.
    always_comb begin
        wcnt_d = '0;
        unique case (phase)
            ST_ACCESS: begin
                if (wcnt_q != WS) begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            default: wcnt_d = '0;
        endcase
    end

    // Register file, prescaler and counter next-state.
    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q + 16'd1;
        expired_d = expired_q;

        if (!ctrl_q[0] || (wr_en && off == A_PRESC) || tick) begin
            pcnt_d = '0;
        end

        if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (ctrl_q[1]) begin
                count_d = load_q;
            end else begin
                ctrl_d[0] = 1'b0;
            end
        end

        if (wr_en && off == A_STATUS && bus.pwdata[0]) begin
            expired_d = 1'b0;
        end
        if (expire) begin
            expired_d = 1'b1;
        end

        if (wr_en) begin
            unique case (off)
                A_CTRL:  ctrl_d  = bus.pwdata[2:0];
                A_LOAD:  load_d  = bus.pwdata;
                A_COUNT: count_d = bus.pwdata;
                A_PRESC: presc_d = bus.pwdata;
                default: ;
            endcase
        end
    end

    // Read mux; zero unless completing a read so slaves can be OR-ed.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            unique case (off)
                A_CTRL:   rdata = {13'd0, ctrl_q};
                A_LOAD:   rdata = load_q;
                A_COUNT:  rdata = count_q;
                A_PRESC:  rdata = presc_q;
                A_STATUS: rdata = {15'd0, expired_q};
                default:  rdata = '0;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            wcnt_q    <= '0;
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            expired_q <= expired_d;
        end
    end

    assign bus.prdata = rdata;
    assign bus.pready = pready;
    assign irq        = expired_q && ctrl_q[2];
endmodule
